// File: rtl/fft_result_serializer.sv
// ---------------------------------------------------------------------------
// fft_result_serializer
//   Captures one frame of eight parallel signed FFT results and streams them
//   out one sample per beat over a valid/ready interface. With REORDER = 1
//   the slots are emitted in bit-reversed order (1,5,3,7,2,6,4,8), which puts
//   the radix-2 datapath output back into natural frequency-bin order.
//
// Ports
//   clk          system clock, all state changes on the rising edge
//   rst          synchronous active-high reset
//   in1..in8     signed frame samples, slot n = in<n>
//   frame_valid  frame on in1..in8 is valid this cycle
//   frame_ready  frame is accepted this cycle (combinational from dout_ready)
//   dout         current serial sample (registered)
//   dout_index   bin index of dout in emission order, 0..7
//   dout_last    high on the 8th beat of a frame
//   dout_valid   dout / dout_index / dout_last are valid
//   dout_ready   consumer accepts the beat
//   frame_drop   one-cycle pulse after a refused frame
//   drop_count   saturating count of refused frames
// ---------------------------------------------------------------------------
module fft_result_serializer #(
  parameter int DW      = 8,
  parameter int REORDER = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [DW-1:0] in1,
  input  logic signed [DW-1:0] in2,
  input  logic signed [DW-1:0] in3,
  input  logic signed [DW-1:0] in4,
  input  logic signed [DW-1:0] in5,
  input  logic signed [DW-1:0] in6,
  input  logic signed [DW-1:0] in7,
  input  logic signed [DW-1:0] in8,
  input  logic                 frame_valid,
  output logic                 frame_ready,
  output logic signed [DW-1:0] dout,
  output logic [2:0]           dout_index,
  output logic                 dout_last,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic                 frame_drop,
  output logic [7:0]           drop_count
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t               r_state;
  logic signed [DW-1:0] r_buf [8];
  logic [2:0]           r_cnt;
  logic signed [DW-1:0] r_dout;
  logic                 r_last;
  logic                 r_valid;
  logic                 r_drop;
  logic [7:0]           r_drop_count;

  logic signed [DW-1:0] w_in [8];
  logic                 w_take;
  logic                 w_refuse;
  logic [2:0]           w_cnt_nxt;

  // Emission position k -> buffer slot (0-based). Bit reversal of a 3-bit
  // index gives exactly the 1,5,3,7,2,6,4,8 slot sequence.
  function automatic logic [2:0] slot_of(input logic [2:0] k);
    return (REORDER != 0) ? {k[0], k[1], k[2]} : k;
  endfunction

  assign w_in[0] = in1;
  assign w_in[1] = in2;
  assign w_in[2] = in3;
  assign w_in[3] = in4;
  assign w_in[4] = in5;
  assign w_in[5] = in6;
  assign w_in[6] = in7;
  assign w_in[7] = in8;

  // Ready in IDLE, or on the last beat when it is being consumed, so a new
  // frame can be captured on the same edge that retires the old one.
  assign frame_ready = (r_state == ST_IDLE) ||
                       ((r_state == ST_SEND) && r_last && dout_ready);

  assign w_take    = frame_valid &&  frame_ready;
  assign w_refuse  = frame_valid && !frame_ready;
  assign w_cnt_nxt = r_cnt + 3'd1;

  // NOTE: the sample buffer has no reset; it is only read in SEND, which is
  // entered exclusively through a capture that overwrites every entry.
  always_ff @(posedge clk) begin
    if (!rst && w_take) begin
      r_buf <= w_in;
    end
  end

  // NOTE: all state here uses non-blocking assignments so every register
  // sees pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 3'd0;
      r_dout       <= '0;
      r_last       <= 1'b0;
      r_valid      <= 1'b0;
      r_drop       <= 1'b0;
      r_drop_count <= 8'd0;
    end else begin
      r_drop <= w_refuse;
      if (w_refuse && (r_drop_count != 8'hFF)) begin
        r_drop_count <= r_drop_count + 8'd1;
      end

      if (w_take) begin
        // Fresh frame: beat 0 comes straight from the inputs, since the
        // buffer only holds the new samples after this edge.
        r_state <= ST_SEND;
        r_cnt   <= 3'd0;
        r_dout  <= w_in[slot_of(3'd0)];
        r_last  <= 1'b0;
        r_valid <= 1'b1;
      end else if ((r_state == ST_SEND) && dout_ready) begin
        if (r_last) begin
          r_state <= ST_IDLE;
          r_cnt   <= 3'd0;
          r_last  <= 1'b0;
          r_valid <= 1'b0;
        end else begin
          r_cnt  <= w_cnt_nxt;
          r_dout <= r_buf[slot_of(w_cnt_nxt)];
          r_last <= (w_cnt_nxt == 3'd7);
        end
      end
    end
  end

  assign dout       = r_dout;
  assign dout_index = r_cnt;
  assign dout_last  = r_last;
  assign dout_valid = r_valid;
  assign frame_drop = r_drop;
  assign drop_count = r_drop_count;

endmodule
